ext_sram_arbiter: RTL

//  Parametrised external SRAM bus controller replacing the fixed CPU/VPU strobe muxing at top level.

---
 rtl/ext_sram_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ext_sram_arbiter.sv
// rtl/ext_sram_arbiter.sv - external SRAM bus arbiter: CPU port plus round-robin read requesters
`timescale 1ns/1ps
module ext_sram_arbiter #(
  parameter int         ADDR_W      = 16,
  parameter int         EXT_AW      = 17,
  parameter int         DATA_W      = 8,
  parameter int         NUM_RD      = 2,
  parameter int         WAIT_STATES = 1,
  parameter int         PAGE_BITS   = 3,
  parameter logic [2:0] WIN_BASE    = 3'b110
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_cs,
  input  logic                     cpu_rw,
  input  logic [ADDR_W-1:0]        cpu_ad,
  input  logic [DATA_W-1:0]        cpu_do,
  output logic [DATA_W-1:0]        cpu_di,
  output logic                     cpu_hold,
  input  logic                     page_en,
  input  logic [PAGE_BITS-1:0]     page,
  input  logic                     page_wp,
  output logic                     wp_err,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*EXT_AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_ack,
  output logic [DATA_W-1:0]        rd_data,
  output logic [EXT_AW-1:0]        sram_ad,
  input  logic [DATA_W-1:0]        sram_dq_i,
  output logic [DATA_W-1:0]        sram_dq_o,
  output logic                     sram_dq_oe,
  output logic                     sram_cs,
  output logic                     sram_oe_n,
  output logic                     sram_we_n
);

  localparam int IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int MAP_W = 1 + PAGE_BITS + ADDR_W - 3;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t             r_state;
  logic [2:0]         r_wait_cnt;
  logic [IDX_W-1:0]   r_rr;
  logic [IDX_W-1:0]   r_sel;
  logic               r_cpu_gnt;
  logic               r_is_rd;
  logic               r_prot;
  logic [EXT_AW-1:0]  r_sram_ad;
  logic [DATA_W-1:0]  r_sram_dq_o;
  logic               r_sram_dq_oe;
  logic               r_sram_cs;
  logic               r_sram_oe_n;
  logic               r_sram_we_n;
  logic [DATA_W-1:0]  r_cpu_di;
  logic [DATA_W-1:0]  r_rd_data;
  logic [NUM_RD-1:0]  r_rd_ack;
  logic               r_wp_err;

  logic               w_in_win;
  logic               w_prot;
  logic [MAP_W-1:0]   w_map_ad;
  logic [EXT_AW-1:0]  w_cpu_ad;
  logic               w_rd_any;
  logic [IDX_W-1:0]   w_rd_sel;
  logic [IDX_W-1:0]   w_rr_next;
  logic [EXT_AW-1:0]  w_rd_ad;

  // CPU address translation: the top-of-space window is redirected into the paged upper half
  assign w_in_win = page_en && (cpu_ad[ADDR_W-1 -: 3] == WIN_BASE);
  assign w_map_ad = {1'b1, page, cpu_ad[ADDR_W-4:0]};
  assign w_cpu_ad = w_in_win ? EXT_AW'(w_map_ad) : EXT_AW'(cpu_ad);
  assign w_prot   = !cpu_rw && w_in_win && page_wp;

  // Round-robin pick: first requester at or above the pointer, else first below it
  always_comb begin
    w_rd_any = 1'b0;
    w_rd_sel = '0;
    w_rd_ad  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!w_rd_any && rd_req[i] && (i >= int'(r_rr))) begin
        w_rd_any = 1'b1;
        w_rd_sel = IDX_W'(i);
        w_rd_ad  = rd_addr[i*EXT_AW +: EXT_AW];
      end
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (!w_rd_any && rd_req[i] && (i < int'(r_rr))) begin
        w_rd_any = 1'b1;
        w_rd_sel = IDX_W'(i);
        w_rd_ad  = rd_addr[i*EXT_AW +: EXT_AW];
      end
    end
  end

  assign w_rr_next = (w_rd_sel == IDX_W'(NUM_RD - 1)) ? '0 : w_rd_sel + 1'b1;

  // Access sequencer: grant in IDLE, hold strobes for WAIT_STATES+1 cycles, one DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_rr         <= '0;
      r_sel        <= '0;
      r_cpu_gnt    <= 1'b0;
      r_is_rd      <= 1'b0;
      r_prot       <= 1'b0;
      r_sram_ad    <= '0;
      r_sram_dq_o  <= '0;
      r_sram_dq_oe <= 1'b0;
      r_sram_cs    <= 1'b0;
      r_sram_oe_n  <= 1'b1;
      r_sram_we_n  <= 1'b1;
      r_cpu_di     <= '0;
      r_rd_data    <= '0;
      r_rd_ack     <= '0;
      r_wp_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rd_ack <= '0;
          r_wp_err <= 1'b0;
          if (w_rd_any) begin
            r_state     <= S_ACCESS;
            r_wait_cnt  <= '0;
            r_sel       <= w_rd_sel;
            r_rr        <= w_rr_next;
            r_cpu_gnt   <= 1'b0;
            r_is_rd     <= 1'b1;
            r_prot      <= 1'b0;
            r_sram_ad   <= w_rd_ad;
            r_sram_cs   <= 1'b1;
            r_sram_oe_n <= 1'b0;
          end else if (cpu_cs) begin
            r_state      <= S_ACCESS;
            r_wait_cnt   <= '0;
            r_cpu_gnt    <= 1'b1;
            r_is_rd      <= cpu_rw;
            r_prot       <= w_prot;
            r_sram_ad    <= w_cpu_ad;
            r_sram_cs    <= 1'b1;
            r_sram_oe_n  <= !cpu_rw;
            // a protected write still runs its cycles but never strobes or drives the bus
            r_sram_we_n  <= cpu_rw || w_prot;
            r_sram_dq_oe <= !cpu_rw && !w_prot;
            if (!cpu_rw) begin
              r_sram_dq_o <= cpu_do;
            end
          end
        end
        S_ACCESS: begin
          if (r_wait_cnt == 3'(WAIT_STATES)) begin
            r_state     <= S_DONE;
            r_sram_oe_n <= 1'b1;
            r_sram_we_n <= 1'b1;
            if (r_is_rd) begin
              if (r_cpu_gnt) begin
                r_cpu_di <= sram_dq_i;
              end else begin
                r_rd_data <= sram_dq_i;
              end
            end
            if (!r_cpu_gnt) begin
              r_rd_ack <= NUM_RD'(1) << r_sel;
            end
            r_wp_err <= r_prot;
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_rd_ack     <= '0;
          r_wp_err     <= 1'b0;
          r_sram_cs    <= 1'b0;
          r_sram_dq_oe <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_hold   = !rst && cpu_cs && !((r_state == S_DONE) && r_cpu_gnt);
  assign cpu_di     = r_cpu_di;
  assign wp_err     = r_wp_err;
  assign rd_ack     = r_rd_ack;
  assign rd_data    = r_rd_data;
  assign sram_ad    = r_sram_ad;
  assign sram_dq_o  = r_sram_dq_o;
  assign sram_dq_oe = r_sram_dq_oe;
  assign sram_cs    = r_sram_cs;
  assign sram_oe_n  = r_sram_oe_n;
  assign sram_we_n  = r_sram_we_n;

endmodule
